// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 4-bit combinational ALU under a
// round-robin IDLE -> EXEC -> RESP controller. The result is registered and
// returned on a valid/ready response channel tagged with the requester ID.
// Optional feature macro: ALU_FLAGS_EN adds registered rsp_zero/rsp_carry.
module alu_arbiter #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_id,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic              busy
`ifdef ALU_FLAGS_EN
    ,
    output logic              rsp_zero,
    output logic              rsp_carry
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_AND = OP_W'(0),
        OP_OR  = OP_W'(1),
        OP_ADD = OP_W'(2),
        OP_SUB = OP_W'(3),
        OP_NOT = OP_W'(4),
        OP_XOR = OP_W'(5),
        OP_DEC = OP_W'(6),
        OP_INC = OP_W'(7)
    } alu_op_e;

    state_e              state_q;
    state_e              state_d;
    logic                rr_ptr;
    alu_op_e             op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                id_q;
    logic [DATA_W-1:0]   alu_res;
    logic                grant;
    logic                rsp_fire;

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign grant     = req0_ready | req1_ready;
    assign rsp_fire  = rsp_valid & rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant decode; ready is suppressed while reset is
    // asserted so a requester never sees an acceptance that reset discards.
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (req0_valid && (!req1_valid || !rr_ptr)) begin
                        req0_ready = 1'b1;
                        state_d    = EXEC;
                    end else if (req1_valid) begin
                        req1_ready = 1'b1;
                        state_d    = EXEC;
                    end
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared ALU, modulo 2^DATA_W.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_NOT:  alu_res = ~a_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_DEC:  alu_res = a_q - DATA_W'(1);
            OP_INC:  alu_res = a_q + DATA_W'(1);
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic alu_carry;

    // Carry-out / borrow of the arithmetic ops evaluated at DATA_W+1 bits.
    always_comb begin
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:  alu_carry = ({1'b0, a_q} + {1'b0, b_q}) > {1'b0, {DATA_W{1'b1}}};
            OP_SUB:  alu_carry = (a_q < b_q);
            OP_DEC:  alu_carry = (a_q == '0);
            OP_INC:  alu_carry = (a_q == '1);
            default: alu_carry = 1'b0;
        endcase
    end

    // Flags are captured alongside the result and held with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_zero  <= (alu_res == '0);
            rsp_carry <= alu_carry;
        end
    end
`endif

    // Operand capture on grant, result capture in EXEC, round-robin update on
    // response handshake, saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_AND;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            rr_ptr     <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant) begin
                op_q <= req1_ready ? alu_op_e'(req1_op) : alu_op_e'(req0_op);
                a_q  <= req1_ready ? req1_a : req0_a;
                b_q  <= req1_ready ? req1_b : req0_b;
                id_q <= req1_ready;
            end
            if (req0_ready && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (req1_ready && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
            if (state_q == EXEC) begin
                rsp_result <= alu_res;
                rsp_id     <= id_q;
            end
            if (rsp_fire) begin
                rr_ptr <= ~rsp_id;
            end
        end
    end

endmodule
